// File: rtl/turn_signal_seq.sv
// Tail-light turn-signal sequencer: mode register, step timer and lamp/HEX decode in one block.
// Requests are sampled only on tick edges (1..TICK_DIV cycles latency); level inputs, no backpressure.
module turn_signal_seq #(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       left_req,
  input  logic                       right_req,
  input  logic                       hazard_req,
  output logic [LAMPS-1:0]           LEDR_L,
  output logic [LAMPS-1:0]           LEDR_R,
  output logic [7:0]                 HEX0,
  output logic [1:0]                 CurrentState,
  output logic [$clog2(LAMPS+1)-1:0] step
);

  localparam int SW = $clog2(LAMPS + 1);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } mode_t;

  logic [CW-1:0] count;
  logic          tick;
  mode_t         state_q, state_d, req_mode;
  logic [SW-1:0] step_q, step_d;
  logic [LAMPS-1:0] therm;

  assign tick = (count == CW'(TICK_DIV - 1));

  // Free-running divider; mode changes never touch it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    req_mode = IDLE;
    if (hazard_req || (left_req && right_req)) begin
      req_mode = HAZARD;
    end else if (left_req) begin
      req_mode = LEFT;
    end else if (right_req) begin
      req_mode = RIGHT;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    if (tick) begin
      if (req_mode != state_q) begin
        state_d = req_mode;
        step_d  = '0;
      end else begin
        unique case (state_q)
          LEFT, RIGHT: step_d = (step_q == SW'(LAMPS)) ? '0 : step_q + SW'(1);
          HAZARD:      step_d = (step_q == '0) ? SW'(LAMPS) : '0;
          default:     step_d = '0;
        endcase
      end
    end
  end

  // Thermometer: lamp i lit when step > i, so step == LAMPS lights the whole bank.
  always_comb begin
    therm = '0;
    for (int unsigned i = 0; i < LAMPS; i++) begin
      therm[i] = (32'(step_q) > i);
    end
  end

  always_comb begin
    LEDR_L = '0;
    LEDR_R = '0;
    HEX0   = 8'hBF;
    unique case (state_q)
      LEFT: begin
        LEDR_L = therm;
        HEX0   = 8'hC7;
      end
      RIGHT: begin
        LEDR_R = therm;
        HEX0   = 8'hAF;
      end
      HAZARD: begin
        LEDR_L = therm;
        LEDR_R = therm;
        HEX0   = 8'h89;
      end
      default: ;
    endcase
  end

  assign CurrentState = state_q;
  assign step         = step_q;

endmodule

// File: tb/tb_turn_signal_seq.sv
// Directed bench: LAMPS=3/TICK_DIV=4 main instance plus two parameter-corner instances.
module tb_turn_signal_seq;

  logic clk = 1'b0;
  logic reset_n;
  logic left_req, right_req, hazard_req;
  logic left1, left8;
  logic zero = 1'b0;

  logic [2:0] ledr_l, ledr_r;
  logic [7:0] hex0;
  logic [1:0] cur_state;
  logic [1:0] step3;

  logic [0:0] l1_l, l1_r;
  logic [7:0] l1_hex;
  logic [1:0] l1_state;
  logic [0:0] l1_step;

  logic [7:0] l8_l, l8_r;
  logic [7:0] l8_hex;
  logic [1:0] l8_state;
  logic [3:0] l8_step;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  turn_signal_seq #(.LAMPS(3), .TICK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .left_req(left_req), .right_req(right_req), .hazard_req(hazard_req),
    .LEDR_L(ledr_l), .LEDR_R(ledr_r), .HEX0(hex0),
    .CurrentState(cur_state), .step(step3)
  );

  turn_signal_seq #(.LAMPS(1), .TICK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .left_req(left1), .right_req(zero), .hazard_req(zero),
    .LEDR_L(l1_l), .LEDR_R(l1_r), .HEX0(l1_hex),
    .CurrentState(l1_state), .step(l1_step)
  );

  turn_signal_seq #(.LAMPS(8), .TICK_DIV(1)) dut8 (
    .clk(clk), .reset_n(reset_n),
    .left_req(left8), .right_req(zero), .hazard_req(zero),
    .LEDR_L(l8_l), .LEDR_R(l8_r), .HEX0(l8_hex),
    .CurrentState(l8_state), .step(l8_step)
  );

  // Advance n rising edges and stop on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; left_req = 1'b1; right_req = 1'b0; hazard_req = 1'b0;
    left1 = 1'b0; left8 = 1'b0;
    #3;
    checks++; if (ledr_l !== 3'b000) begin errors++; $display("FAIL reset_ledr_l got %b expected 000", ledr_l); end
    checks++; if (ledr_r !== 3'b000) begin errors++; $display("FAIL reset_ledr_r got %b expected 000", ledr_r); end
    checks++; if (hex0 !== 8'hBF) begin errors++; $display("FAIL reset_hex got %h expected bf", hex0); end
    checks++; if (cur_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", cur_state); end
    @(negedge clk);
    reset_n = 1'b1;
    cyc(3);
    checks++; if (cur_state !== 2'd0 || ledr_l !== 3'b000) begin errors++; $display("FAIL pre_tick_idle got state %0d ledr_l %b expected 0 000", cur_state, ledr_l); end
    cyc(1);
    checks++; if (cur_state !== 2'd1 || step3 !== 2'd0) begin errors++; $display("FAIL first_tick_left got state %0d step %0d expected 1 0", cur_state, step3); end
    checks++; if (ledr_l !== 3'b000 || hex0 !== 8'hC7) begin errors++; $display("FAIL first_tick_decode got ledr_l %b hex %h expected 000 c7", ledr_l, hex0); end
  endtask

  task automatic test_left_sweep;
    logic [2:0] exp_l [5] = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001};
    cyc(2);
    checks++; if (ledr_l !== 3'b000) begin errors++; $display("FAIL between_ticks got %b expected 000", ledr_l); end
    cyc(2);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) cyc(4);
      checks++;
      if (ledr_l !== exp_l[k] || ledr_r !== 3'b000) begin
        errors++; $display("FAIL left_sweep[%0d] got L %b R %b expected L %b R 000", k, ledr_l, ledr_r, exp_l[k]);
      end
    end
  endtask

  task automatic test_mid_switch;
    logic [2:0] exp_r [3] = '{3'b001, 3'b011, 3'b111};
    cyc(4);
    checks++; if (ledr_l !== 3'b011) begin errors++; $display("FAIL pre_switch got %b expected 011", ledr_l); end
    left_req = 1'b0; right_req = 1'b1;
    cyc(4);
    checks++; if (cur_state !== 2'd2 || step3 !== 2'd0) begin errors++; $display("FAIL switch_right got state %0d step %0d expected 2 0", cur_state, step3); end
    checks++; if (ledr_l !== 3'b000 || ledr_r !== 3'b000 || hex0 !== 8'hAF) begin errors++; $display("FAIL switch_decode got L %b R %b hex %h expected 000 000 af", ledr_l, ledr_r, hex0); end
    for (int k = 0; k < 3; k++) begin
      cyc(4);
      checks++;
      if (ledr_r !== exp_r[k] || ledr_l !== 3'b000) begin
        errors++; $display("FAIL right_sweep[%0d] got R %b L %b expected R %b L 000", k, ledr_r, ledr_l, exp_r[k]);
      end
    end
  endtask

  task automatic test_hazard;
    logic [2:0] exp_b [6] = '{3'b000, 3'b111, 3'b000, 3'b111, 3'b000, 3'b111};
    left_req = 1'b1; right_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin left_req = 1'b0; right_req = 1'b0; hazard_req = 1'b1; end
      cyc(4);
      checks++;
      if (cur_state !== 2'd3 || hex0 !== 8'h89 || ledr_l !== exp_b[k] || ledr_r !== exp_b[k]) begin
        errors++; $display("FAIL hazard[%0d] got state %0d hex %h L %b R %b expected 3 89 %b %b",
                           k, cur_state, hex0, ledr_l, ledr_r, exp_b[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_glitch;
    hazard_req = 1'b0;
    cyc(4);
    checks++; if (cur_state !== 2'd0 || hex0 !== 8'hBF) begin errors++; $display("FAIL back_to_idle got state %0d hex %h expected 0 bf", cur_state, hex0); end
    right_req = 1'b1;
    cyc(1);
    right_req = 1'b0;
    cyc(3);
    checks++; if (cur_state !== 2'd0 || ledr_r !== 3'b000) begin errors++; $display("FAIL glitch_ignored got state %0d R %b expected 0 000", cur_state, ledr_r); end
  endtask

  task automatic test_async_reset;
    hazard_req = 1'b1;
    cyc(8);
    checks++; if (ledr_l !== 3'b111 || ledr_r !== 3'b111) begin errors++; $display("FAIL hazard_lit got L %b R %b expected 111 111", ledr_l, ledr_r); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ledr_l !== 3'b000 || ledr_r !== 3'b000 || hex0 !== 8'hBF || cur_state !== 2'd0 || step3 !== 2'd0) begin
      errors++; $display("FAIL async_clear got L %b R %b hex %h state %0d step %0d expected 000 000 bf 0 0",
                         ledr_l, ledr_r, hex0, cur_state, step3);
    end
    @(negedge clk);
    reset_n = 1'b1;
    cyc(3);
    checks++; if (cur_state !== 2'd0) begin errors++; $display("FAIL resume_wait got state %0d expected 0", cur_state); end
    cyc(1);
    checks++; if (cur_state !== 2'd3 || hex0 !== 8'h89) begin errors++; $display("FAIL resume_hazard got state %0d hex %h expected 3 89", cur_state, hex0); end
    hazard_req = 1'b0;
  endtask

  task automatic test_corners;
    logic       exp1 [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] exp8 [10] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
    left1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      checks++;
      if (l1_l[0] !== exp1[k] || l1_state !== 2'd1) begin
        errors++; $display("FAIL lamps1_toggle[%0d] got %b state %0d expected %b 1", k, l1_l[0], l1_state, exp1[k]);
      end
    end
    left8 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      checks++;
      if (l8_l !== exp8[k] || l8_r !== 8'h00 || l8_step > 4'd8) begin
        errors++; $display("FAIL lamps8_sweep[%0d] got L %h R %h step %0d expected L %h R 00", k, l8_l, l8_r, l8_step, exp8[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_left_sweep();
    test_mid_switch();
    test_hazard();
    test_glitch();
    test_async_reset();
    test_corners();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/turn_signal_seq.md
# turn_signal_seq

Parametrised tail-light turn-signal sequencer for the lab's light-control path. It combines the state register, the step timer and the output decode in one block. It supports a configurable lamp count per side, a configurable step period, and left, right and hazard modes with request priority. It drives the left and right lamp banks and a HEX0 mode indicator directly from board switches.

## Interface

Parameters:
- LAMPS, 3: lamps per side; legal range 1..8.
- TICK_DIV, 25_000_000: clk cycles per sequence step; legal range ≥1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- left_req  input  1  left-turn request, level, synchronous to clk.
- right_req  input  1  right-turn request, level.
- hazard_req  input  1  hazard request, level.
- LEDR_L  output  LAMPS  left lamp bank; bit 0 = innermost lamp; 1 = lit.
- LEDR_R  output  LAMPS  right lamp bank; bit 0 = innermost lamp.
- HEX0  output  8  seven-segment mode indicator, active-low; bit0=a … bit6=g, bit7=dp (always 1).
- CurrentState  output  2  mode register: 0=IDLE, 1=LEFT, 2=RIGHT, 3=HAZARD.
- step  output  $clog2(LAMPS+1)  current sequence step, 0..LAMPS.

## Operation

- Tick counter: free-running, counts 0..TICK_DIV-1, then wraps to 0. tick = (count == TICK_DIV-1). TICK_DIV=1 gives tick on every cycle.
- Requested mode, combinational, by priority:
  - hazard_req, or left_req & right_req → HAZARD
  - else left_req → LEFT
  - else right_req → RIGHT
  - else IDLE
- State update happens only on edges where tick=1:
  - If requested ≠ CurrentState: CurrentState ← requested, step ← 0 (restart).
  - Else in LEFT/RIGHT: step ← (step == LAMPS) ? 0 : step+1.
  - Else in HAZARD: step ← (step == 0) ? LAMPS : 0.
  - Else in IDLE: step ← 0.
- Lamp decode, combinational from the registers:
  - Thermometer T(step) = lamps 0..step-1 lit; T(0) = all off; T(LAMPS) = all on.
  - IDLE: both banks 0.
  - LEFT: LEDR_L = T(step), LEDR_R = 0.
  - RIGHT: LEDR_R = T(step), LEDR_L = 0.
  - HAZARD: both banks = T(step), which is all on or all off.
- HEX0: IDLE '-' = 8'hBF; LEFT 'L' = 8'hC7; RIGHT 'r' = 8'hAF; HAZARD 'H' = 8'h89.
- Request changes between ticks are ignored. Only the level present on the tick edge matters, so no debounce is needed at step rates.

## Timing

- Reset (async assert): count=0, CurrentState=IDLE, step=0. LEDR_L=LEDR_R=0, HEX0=8'hBF, all immediately and independent of clk.
- After reset release, the first tick is on the TICK_DIV-th rising edge.
- Request-to-display latency: 1..TICK_DIV cycles, landing on the next tick edge.
- Outputs change only on tick edges or at reset. There are no glitches between ticks because the outputs decode from registers only.
- LEFT/RIGHT sweep period = (LAMPS+1)·TICK_DIV cycles. HAZARD blink period = 2·TICK_DIV cycles.
- Boundary cases:
  - Mode switch mid-sweep always restarts at step 0 (dark), including LEFT→RIGHT and LEFT→HAZARD.
  - A request dropped and re-raised within one tick interval is invisible.
  - The tick counter is not reset by mode changes.
  - step never exceeds LAMPS.
  - Reset mid-sweep clears everything asynchronously. Operation resumes from count=0.

## Test plan

Use LAMPS=3, TICK_DIV=4 unless stated.

1. Reset: hold reset_n=0 with left_req=1 → LEDR_L=LEDR_R=3'b000, HEX0=8'hBF, CurrentState=0. Release reset → no change until edge 4.
2. Left sweep: left_req=1 → on successive ticks (every 4 clk):
   - CurrentState=1, step 0, LEDR_L=000, HEX0=8'hC7
   - then LEDR_L=001, 011, 111, 000, 001 …
   - LEDR_R stays 000 throughout.
3. Mid-sweep switch: at LEDR_L=011, swap to right_req=1 → next tick gives CurrentState=2, step=0, both banks 000, HEX0=8'hAF. The following ticks give LEDR_R=001, 011, 111.
4. Hazard priority: left_req=right_req=1 → CurrentState=3, HEX0=8'h89. Both banks alternate 000/111 every tick. hazard_req alone gives identical behaviour.
5. Parameter corners:
   - TICK_DIV=1, LAMPS=1, left_req=1 → LEDR_L toggles 0/1 every cycle.
   - LAMPS=8 → full 9-step sweep ending at LEDR_L=8'hFF.
6. Ignored glitch and async reset:
   - A 1-cycle right_req pulse between ticks in IDLE → no state change.
   - Asserting reset_n=0 mid-cycle during HAZARD → outputs clear before the next clk edge.
